// File: rtl/inta_sequencer_8259a_pkg.sv
// Shared 8259A types: acknowledge-sequencer state encoding and one-hot/index helpers.
package inta_sequencer_8259a_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t PENDING = 3'd1;
  localparam state_t ACK1    = 3'd2;
  localparam state_t WAIT2   = 3'd3;
  localparam state_t ACK2    = 3'd4;

  // The highest set bit wins, so a malformed mask still yields a defined index.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] num_to_onehot(input logic [2:0] num);
    return 8'(1) << num;
  endfunction

endpackage

// File: rtl/inta_sequencer_8259a_if.sv
// Bus between the 8259A control core and the INTA sequencer; the sequencer takes the slave modport.
interface inta_sequencer_8259a_if;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic       interrupt_acknowledge_n;
  logic       auto_eoi_config;
  logic [4:0] interrupt_vector_address;
  logic       eoi_strobe;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       interrupt_to_cpu;
  logic       latch_in_service;
  logic [7:0] acknowledged_level;
  logic [7:0] clear_interrupt_request;
  logic [7:0] end_of_interrupt;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;

  modport master (
    output interrupt, highest_level_in_service, interrupt_acknowledge_n, auto_eoi_config,
           interrupt_vector_address, eoi_strobe, eoi_specific, eoi_level,
    input  interrupt_to_cpu, latch_in_service, acknowledged_level, clear_interrupt_request,
           end_of_interrupt, out_control_logic_data, control_logic_data
  );

  modport slave (
    input  interrupt, highest_level_in_service, interrupt_acknowledge_n, auto_eoi_config,
           interrupt_vector_address, eoi_strobe, eoi_specific, eoi_level,
    output interrupt_to_cpu, latch_in_service, acknowledged_level, clear_interrupt_request,
           end_of_interrupt, out_control_logic_data, control_logic_data
  );
endinterface

// File: rtl/inta_sequencer_8259a_edge_detect.sv
// Registers the synchronised INTA pin and flags its falling/rising edges combinationally.
// The register resets high so an INTA held low across reset release reads as a (harmless) fall.
module inta_edge_detect_8259a (
  input  logic clock,
  input  logic reset_n,
  input  logic i_inta_n,
  output logic o_fall,
  output logic o_rise
);

  logic r_inta_n_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_inta_n_q <= 1'b1;
    else          r_inta_n_q <= i_inta_n;
  end

  assign o_fall = r_inta_n_q & ~i_inta_n;
  assign o_rise = ~r_inta_n_q & i_inta_n;

endmodule

// File: rtl/inta_sequencer_8259a.sv
// 8086-mode INTA handshake: raises INT, issues latch/IRR-clear/EOI strobes, drives the vector.
// Every output is registered: an event sampled on one clock edge shows up in the following cycle.
module inta_sequencer_8259a
  import inta_sequencer_8259a_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  inta_sequencer_8259a_if.slave  bus
);

  state_t     r_state, w_next_state;
  logic       w_fall, w_rise, w_irq_any;

  logic       r_int, r_latch, r_oe, r_spurious;
  logic [7:0] r_ack_level, r_clear, r_eoi, r_data;

  logic       w_int_nxt, w_latch_nxt, w_oe_nxt, w_spur_nxt;
  logic [7:0] w_ack_nxt, w_clear_nxt, w_eoi_nxt, w_data_nxt, w_aeoi_mask, w_cmd_mask;

  inta_edge_detect_8259a u_edge (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_inta_n (bus.interrupt_acknowledge_n),
    .o_fall   (w_fall),
    .o_rise   (w_rise)
  );

  assign w_irq_any = |bus.interrupt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_irq_any) w_next_state = PENDING;
      PENDING: if (w_fall)    w_next_state = ACK1;
      ACK1:    if (w_rise)    w_next_state = WAIT2;
      WAIT2:   if (w_fall)    w_next_state = ACK2;
      ACK2:    if (w_rise)    w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_int_nxt   = r_int;
    w_latch_nxt = 1'b0;
    w_clear_nxt = 8'h00;
    w_ack_nxt   = r_ack_level;
    w_spur_nxt  = r_spurious;
    w_oe_nxt    = r_oe;
    w_data_nxt  = r_data;
    w_aeoi_mask = 8'h00;
    w_cmd_mask  = 8'h00;
    case (r_state)
      IDLE: if (w_irq_any) w_int_nxt = 1'b1;
      // A request that vanished before INTA is acknowledged as IR7 with no side effects.
      PENDING: if (w_fall) begin
        w_int_nxt   = 1'b0;
        w_latch_nxt = w_irq_any;
        w_clear_nxt = bus.interrupt;
        w_ack_nxt   = w_irq_any ? bus.interrupt : 8'h80;
        w_spur_nxt  = ~w_irq_any;
      end
      WAIT2: if (w_fall) begin
        w_oe_nxt   = 1'b1;
        w_data_nxt = {bus.interrupt_vector_address, onehot_to_index(r_ack_level)};
      end
      ACK2: if (w_rise) begin
        w_oe_nxt = 1'b0;
        if (bus.auto_eoi_config && !r_spurious) w_aeoi_mask = r_ack_level;
      end
      default: ;
    endcase
    if (bus.eoi_strobe)
      w_cmd_mask = bus.eoi_specific ? num_to_onehot(bus.eoi_level) : bus.highest_level_in_service;
    w_eoi_nxt = w_aeoi_mask | w_cmd_mask;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_int       <= 1'b0;
      r_latch     <= 1'b0;
      r_oe        <= 1'b0;
      r_spurious  <= 1'b0;
      r_ack_level <= 8'h00;
      r_clear     <= 8'h00;
      r_eoi       <= 8'h00;
      r_data      <= 8'h00;
    end else begin
      r_int       <= w_int_nxt;
      r_latch     <= w_latch_nxt;
      r_oe        <= w_oe_nxt;
      r_spurious  <= w_spur_nxt;
      r_ack_level <= w_ack_nxt;
      r_clear     <= w_clear_nxt;
      r_eoi       <= w_eoi_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign bus.interrupt_to_cpu        = r_int;
  assign bus.latch_in_service        = r_latch;
  assign bus.acknowledged_level      = r_ack_level;
  assign bus.clear_interrupt_request = r_clear;
  assign bus.end_of_interrupt        = r_eoi;
  assign bus.out_control_logic_data  = r_oe;
  assign bus.control_logic_data      = r_data;

endmodule

// File: tb/tb_inta_sequencer_8259a.sv
// Scoreboard bench for inta_sequencer_8259a: expected strobes queued at stimulus time, popped by a monitor.
module tb_inta_sequencer_8259a;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  inta_sequencer_8259a_if bus();

  inta_sequencer_8259a dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q_latch[$];
  logic [7:0] q_vec[$];
  logic [7:0] q_eoi[$];
  logic prev_oe = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Strobes are compared against the queues; anything firing with an empty queue is an error.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.latch_in_service) begin
        if (q_latch.size() == 0) check("latch_unexpected", 8'h01, 8'h00);
        else begin
          check("irr_clear", bus.clear_interrupt_request, q_latch[0]);
          check("ack_level", bus.acknowledged_level, q_latch.pop_front());
        end
      end else if (bus.clear_interrupt_request != 8'h00) begin
        check("clear_unexpected", bus.clear_interrupt_request, 8'h00);
      end
      if (bus.out_control_logic_data && !prev_oe) begin
        if (q_vec.size() == 0) check("vector_unexpected", 8'h01, 8'h00);
        else check("vector", bus.control_logic_data, q_vec.pop_front());
      end
      if (bus.end_of_interrupt != 8'h00) begin
        if (q_eoi.size() == 0) check("eoi_unexpected", bus.end_of_interrupt, 8'h00);
        else check("eoi", bus.end_of_interrupt, q_eoi.pop_front());
      end
    end
    prev_oe = bus.out_control_logic_data;
  end

  // Runs from IDLE through the second INTA falling edge, leaving the DUT in ACK2.
  task automatic to_ack2(input logic [7:0] irq, input logic [7:0] irq_at_ack,
                         input logic [7:0] exp_vec, input bit push_vec);
    bus.interrupt = irq;
    tick();
    check("int_rise", 8'(bus.interrupt_to_cpu), 8'h01);
    bus.interrupt = irq_at_ack;
    tick();
    tick();
    check("int_hold", 8'(bus.interrupt_to_cpu), 8'h01);
    if (irq_at_ack != 8'h00) q_latch.push_back(irq_at_ack);
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    check("int_fall", 8'(bus.interrupt_to_cpu), 8'h00);
    tick();
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    check("oe_idle", 8'(bus.out_control_logic_data), 8'h00);
    if (push_vec) q_vec.push_back(exp_vec);
    bus.interrupt_acknowledge_n = 1'b0;
    tick();
    check("oe_rise", 8'(bus.out_control_logic_data), 8'h01);
  endtask

  task automatic finish_ack(input bit cmd, input bit spec, input logic [2:0] lvl,
                            input logic [7:0] exp_eoi, input bit keep_irq);
    if (!keep_irq) bus.interrupt = 8'h00;
    tick();
    bus.eoi_strobe   = cmd;
    bus.eoi_specific = spec;
    bus.eoi_level    = lvl;
    if (exp_eoi != 8'h00) q_eoi.push_back(exp_eoi);
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    bus.eoi_strobe = 1'b0;
    check("oe_fall", 8'(bus.out_control_logic_data), 8'h00);
    check("eoi_at_rise", bus.end_of_interrupt, exp_eoi);
    tick();
    check("eoi_width", bus.end_of_interrupt, 8'h00);
    check("int_after_ack", 8'(bus.interrupt_to_cpu), 8'(keep_irq));
  endtask

  task automatic eoi_cmd(input bit spec, input logic [2:0] lvl, input logic [7:0] hlis,
                         input logic [7:0] exp_eoi);
    bus.highest_level_in_service = hlis;
    bus.eoi_specific = spec;
    bus.eoi_level    = lvl;
    bus.eoi_strobe   = 1'b1;
    if (exp_eoi != 8'h00) q_eoi.push_back(exp_eoi);
    tick();
    bus.eoi_strobe = 1'b0;
    check("eoi_cmd", bus.end_of_interrupt, exp_eoi);
    tick();
    check("eoi_cmd_width", bus.end_of_interrupt, 8'h00);
  endtask

  initial begin
    bus.interrupt                = 8'h00;
    bus.highest_level_in_service = 8'h00;
    bus.interrupt_acknowledge_n  = 1'b1;
    bus.auto_eoi_config          = 1'b0;
    bus.interrupt_vector_address = 5'h00;
    bus.eoi_strobe               = 1'b0;
    bus.eoi_specific             = 1'b0;
    bus.eoi_level                = 3'd0;
    tick();
    tick();
    check("rst_int",   8'(bus.interrupt_to_cpu), 8'h00);
    check("rst_latch", 8'(bus.latch_in_service), 8'h00);
    check("rst_ack",   bus.acknowledged_level, 8'h00);
    check("rst_clear", bus.clear_interrupt_request, 8'h00);
    check("rst_eoi",   bus.end_of_interrupt, 8'h00);
    check("rst_oe",    8'(bus.out_control_logic_data), 8'h00);
    check("rst_data",  bus.control_logic_data, 8'h00);
    reset_n = 1'b1;
    tick();
    check("idle_no_int", 8'(bus.interrupt_to_cpu), 8'h00);

    // Normal acknowledge, AEOI off: vector {10h, 3} = 83h.
    bus.interrupt_vector_address = 5'h10;
    to_ack2(8'h08, 8'h08, 8'h83, 1'b1);
    finish_ack(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("data_hold", bus.control_logic_data, 8'h83);

    // AEOI on.
    bus.auto_eoi_config = 1'b1;
    to_ack2(8'h08, 8'h08, 8'h83, 1'b1);
    finish_ack(1'b0, 1'b0, 3'd0, 8'h08, 1'b0);

    // Spurious: request withdrawn before INTA, acknowledged as IR7, no AEOI.
    to_ack2(8'h02, 8'h00, 8'h87, 1'b1);
    check("spurious_ack", bus.acknowledged_level, 8'h80);
    finish_ack(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // EOI commands in IDLE.
    bus.auto_eoi_config = 1'b0;
    eoi_cmd(1'b0, 3'd0, 8'h20, 8'h20);
    eoi_cmd(1'b1, 3'd3, 8'h20, 8'h08);
    eoi_cmd(1'b0, 3'd5, 8'h00, 8'h00);

    // Specific level-1 command coinciding with the AEOI pulse for IR2.
    bus.auto_eoi_config = 1'b1;
    bus.interrupt_vector_address = 5'h08;
    to_ack2(8'h04, 8'h04, 8'h42, 1'b1);
    finish_ack(1'b1, 1'b1, 3'd1, 8'h06, 1'b0);

    // Back-to-back: request kept asserted re-raises INT right after ACK2.
    bus.auto_eoi_config = 1'b0;
    bus.interrupt_vector_address = 5'h0A;
    to_ack2(8'h10, 8'h10, 8'h54, 1'b1);
    finish_ack(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    to_ack2(8'h10, 8'h10, 8'h54, 1'b1);
    finish_ack(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // Reset while the vector is on the bus in ACK2.
    bus.auto_eoi_config = 1'b1;
    bus.interrupt_vector_address = 5'h10;
    to_ack2(8'h08, 8'h08, 8'h83, 1'b0);
    check("pre_rst_data", bus.control_logic_data, 8'h83);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_oe",   8'(bus.out_control_logic_data), 8'h00);
    check("rst_async_data", bus.control_logic_data, 8'h00);
    bus.interrupt = 8'h00;
    bus.interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("rst_no_eoi", bus.end_of_interrupt, 8'h00);
    check("rst_no_int", 8'(bus.interrupt_to_cpu), 8'h00);
    bus.interrupt = 8'h01;
    tick();
    check("rst_idle_int", 8'(bus.interrupt_to_cpu), 8'h01);
    bus.interrupt = 8'h00;
    tick();
    tick();

    check("q_latch_empty", 8'(q_latch.size()), 8'h00);
    check("q_vec_empty",   8'(q_vec.size()), 8'h00);
    check("q_eoi_empty",   8'(q_eoi.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
